// File: rtl/zspan_fill.sv
// Scanline span filler: finds the left/right edge pixels of a row in the edge mask,
// then walks the span with interpolated depth, z-tests each pixel and writes colour/depth.
module zspan_fill #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int Z_W     = 8,
  parameter int FRAC_W  = 8,
  parameter int COLOR_W = 24,
  parameter int RD_LAT  = 1,
  parameter int ADDR_W  = $clog2(WIDTH*HEIGHT)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [$clog2(HEIGHT)-1:0]  row,
  input  logic [Z_W+FRAC_W-1:0]      z0,
  input  logic [Z_W+FRAC_W:0]        dzdx,
  input  logic [COLOR_W-1:0]         color,
  input  logic [1:0]                 depth_func,
  input  logic                       z_write,
  output logic [ADDR_W-1:0]          mask_addr,
  input  logic                       mask_data,
  output logic [ADDR_W-1:0]          zb_rd_addr,
  input  logic [Z_W-1:0]             zb_rd_data,
  output logic                       zb_wr_en,
  output logic [ADDR_W-1:0]          zb_wr_addr,
  output logic [Z_W-1:0]             zb_wr_data,
  output logic                       fb_wr_en,
  output logic [ADDR_W-1:0]          fb_addr,
  output logic [COLOR_W-1:0]         fb_data,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] px_written
);

  localparam int XW    = $clog2(WIDTH);
  localparam int ZA_W  = Z_W + FRAC_W;
  localparam int DZ_W  = ZA_W + 1;
  localparam int ACC_W = ZA_W + 3;
  localparam int CW    = $clog2(RD_LAT + 1);
  localparam int PW    = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, SCAN_L, SCAN_R, ZREAD, ZTEST, WRITE, STEP, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [XW-1:0]       x_q, x_d;
  logic [XW-1:0]       l_q, l_d;
  logic [XW-1:0]       r_q, r_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0]    zacc_q, zacc_d;
  logic [ZA_W-1:0]     z0_q, z0_d;
  logic [DZ_W-1:0]     dzdx_q, dzdx_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic [1:0]          dfunc_q, dfunc_d;
  logic                zwr_q, zwr_d;
  logic [Z_W-1:0]      znew_q, znew_d;
  logic [PW-1:0]       px_q, px_d;

  logic [ADDR_W-1:0]   pixAddr;
  logic [Z_W-1:0]      znew;
  logic                pass;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      x_q     <= '0;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zacc_q  <= '0;
      z0_q    <= '0;
      dzdx_q  <= '0;
      color_q <= '0;
      dfunc_q <= '0;
      zwr_q   <= 1'b0;
      znew_q  <= '0;
      px_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      x_q     <= x_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zacc_q  <= zacc_d;
      z0_q    <= z0_d;
      dzdx_q  <= dzdx_d;
      color_q <= color_d;
      dfunc_q <= dfunc_d;
      zwr_q   <= zwr_d;
      znew_q  <= znew_d;
      px_q    <= px_d;
    end
  end

  // Integer depth, clamped: negative accumulators give 0, anything past the top gives all ones.
  always_comb begin
    if (zacc_q[ACC_W-1])
      znew = '0;
    else if (|zacc_q[ACC_W-2:ZA_W])
      znew = '1;
    else
      znew = zacc_q[FRAC_W +: Z_W];
  end

  always_comb begin
    case (dfunc_q)
      2'b00:   pass = (znew > zb_rd_data);
      2'b01:   pass = (znew < zb_rd_data);
      2'b10:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    x_d     = x_q;
    l_d     = l_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zacc_d  = zacc_q;
    z0_d    = z0_q;
    dzdx_d  = dzdx_q;
    color_d = color_q;
    dfunc_d = dfunc_q;
    zwr_d   = zwr_q;
    znew_d  = znew_q;
    px_d    = px_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = ADDR_W'(row) * ADDR_W'(WIDTH);
          z0_d    = z0;
          dzdx_d  = dzdx;
          color_d = color;
          dfunc_d = depth_func;
          zwr_d   = z_write;
          x_d     = '0;
          cnt_d   = '0;
          px_d    = '0;
          state_d = SCAN_L;
        end
      end
      // Each mask probe holds its address for RD_LAT cycles and samples on the next one.
      SCAN_L: begin
        if (cnt_q == CW'(RD_LAT)) begin
          cnt_d = '0;
          if (mask_data) begin
            l_d     = x_q;
            x_d     = XW'(WIDTH - 1);
            state_d = SCAN_R;
          end else if (x_q == XW'(WIDTH - 1)) begin
            state_d = DONE;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCAN_R: begin
        if (cnt_q == CW'(RD_LAT)) begin
          cnt_d = '0;
          if (mask_data || (x_q == l_q)) begin
            r_d     = x_q;
            x_d     = l_q;
            zacc_d  = {{3{1'b0}}, z0_q};
            state_d = ZREAD;
          end else begin
            x_d = x_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ZREAD: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ZTEST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ZTEST: begin
        znew_d  = znew;
        state_d = pass ? WRITE : STEP;
      end
      WRITE: begin
        px_d    = px_q + 1'b1;
        state_d = STEP;
      end
      STEP: begin
        zacc_d = zacc_q + {{2{dzdx_q[DZ_W-1]}}, dzdx_q};
        cnt_d  = '0;
        if (x_q == r_q) begin
          state_d = DONE;
        end else begin
          x_d     = x_q + 1'b1;
          state_d = ZREAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pixAddr    = base_q + ADDR_W'(x_q);
  assign mask_addr  = pixAddr;
  assign zb_rd_addr = pixAddr;
  assign zb_wr_addr = pixAddr;
  assign fb_addr    = pixAddr;
  assign fb_data    = color_q;
  assign zb_wr_data = znew_q;
  assign fb_wr_en   = (state_q == WRITE);
  assign zb_wr_en   = (state_q == WRITE) && zwr_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign px_written = px_q;

endmodule
